io_timer: RTL and testbench

//  Programmable down-counting timer peripheral on the CPU IO bus, decoded in IO slot 3 (addr[8:5]==3).

---
 rtl/io_timer_pkg.sv | 49 ++++
 rtl/io_timer_if.sv | 37 +++
 rtl/io_timer_prescale.sv | 36 +++
 rtl/io_timer.sv | 137 +++++++++++++
 tb/tb_io_timer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_timer_pkg.sv
// -----------------------------------------------------------------------------
// io_timer_pkg
//   Shared definitions for the IO-slot-3 programmable timer.
//   - tmr_reg_e   : register word indices as seen on io_addr (CPU addr[4:1])
//   - CTRL_*      : bit positions inside the CTRL register
//   - tmr_ctrl_t  : packed view of the CTRL register
//   - CNT_W       : width of the down counter and reload value
// -----------------------------------------------------------------------------
package io_timer_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    TMR_CTRL     = 4'd0,
    TMR_STATUS   = 4'd1,
    TMR_PRESCALE = 4'd2,
    TMR_RELOAD   = 4'd3,
    TMR_COUNT    = 4'd4
  } tmr_reg_e;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IE       = 2;

  // Bit order matches the register image: ie=bit2, periodic=bit1, en=bit0.
  typedef struct packed {
    logic ie;
    logic periodic;
    logic en;
  } tmr_ctrl_t;

  function automatic tmr_ctrl_t ctrl_from_word(input logic [2:0] w);
    tmr_ctrl_t c;
    c.en       = w[CTRL_EN];
    c.periodic = w[CTRL_PERIODIC];
    c.ie       = w[CTRL_IE];
    return c;
  endfunction

  function automatic logic [2:0] ctrl_to_word(input tmr_ctrl_t c);
    logic [2:0] w;
    w                = '0;
    w[CTRL_EN]       = c.en;
    w[CTRL_PERIODIC] = c.periodic;
    w[CTRL_IE]       = c.ie;
    return w;
  endfunction

endpackage

// File: rtl/io_timer_if.sv
// -----------------------------------------------------------------------------
// io_timer_if
//   CPU IO bus as seen by one peripheral slot.
//   io_addr   : register word index (CPU addr[4:1])
//   io_write  : single-cycle write strobe, already slot-decoded and fault-gated
//   io_read   : read qualifier (reads have no side effects)
//   io_wdata  : write data
//   io_rdata  : read data, combinational from io_addr
//   master = CPU side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface io_timer_if #(
  parameter int unsigned RV = 16
);

  logic [3:0]    io_addr;
  logic          io_write;
  logic          io_read;
  logic [RV-1:0] io_wdata;
  logic [RV-1:0] io_rdata;

  modport master (
    output io_addr,
    output io_write,
    output io_read,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_addr,
    input  io_write,
    input  io_read,
    input  io_wdata,
    output io_rdata
  );

endinterface

// File: rtl/io_timer_prescale.sv
// -----------------------------------------------------------------------------
// io_timer_prescale
//   Clock prescaler for io_timer. While enabled, the internal count advances
//   every clk; when it equals i_presc a one-cycle tick is issued and the count
//   restarts from 0 on the same edge, so ticks arrive every i_presc+1 clks.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     i_en       : prescaler enable; when low the count is held at 0
//     i_clear    : restart the count from 0 on the next edge
//     i_presc    : division value (tick period = i_presc+1 clks)
//     o_tick     : combinational tick, valid in the cycle before the edge
// -----------------------------------------------------------------------------
module io_timer_prescale #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic               i_clear,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_pcnt;

  assign o_tick = i_en && (r_pcnt == i_presc);

  always_ff @(posedge clk) begin
    if (reset || !i_en || i_clear || o_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// -----------------------------------------------------------------------------
// io_timer
//   Programmable 16-bit down-counting timer on the CPU IO bus (slot 3).
//   Registers (io_addr):
//     0 CTRL     {bit2 ie, bit1 periodic, bit0 en}, other bits RAZ/WI
//     1 STATUS   {bit0 expired}, write-1-to-clear
//     2 PRESCALE [PRESC_W-1:0], write restarts the prescaler
//     3 RELOAD   [15:0], used at the next periodic reload only
//     4 COUNT    [15:0], read = live count, write = load (restarts prescaler)
//     5..15      read 0, writes ignored
//   On each prescaler tick a non-zero COUNT decrements; a zero COUNT expires:
//   STATUS.expired is set, then periodic mode reloads COUNT from RELOAD and
//   one-shot mode clears CTRL.en and leaves COUNT at 0.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     bus        : io_timer_if slave (io_addr/io_write/io_read/io_wdata/io_rdata)
//     interrupt  : level, STATUS.expired & CTRL.ie
// -----------------------------------------------------------------------------
module io_timer
  import io_timer_pkg::*;
#(
  parameter int unsigned RV      = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  io_timer_if.slave   bus,
  output logic        interrupt
);

  tmr_ctrl_t          r_ctrl;
  logic               r_expired;
  logic [PRESC_W-1:0] r_presc;
  logic [CNT_W-1:0]   r_reload;
  logic [CNT_W-1:0]   r_count;

  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_wr_presc;
  logic w_wr_reload;
  logic w_wr_count;
  logic w_start;
  logic w_pclear;
  logic w_tick;
  logic w_tick_eff;
  logic w_expire;
  logic w_clr_status;
  logic w_unused_read;

  // Reads are side-effect free, so the qualifier is not needed internally.
  assign w_unused_read = bus.io_read;

  assign w_wr_ctrl   = bus.io_write && (bus.io_addr == TMR_CTRL);
  assign w_wr_status = bus.io_write && (bus.io_addr == TMR_STATUS);
  assign w_wr_presc  = bus.io_write && (bus.io_addr == TMR_PRESCALE);
  assign w_wr_reload = bus.io_write && (bus.io_addr == TMR_RELOAD);
  assign w_wr_count  = bus.io_write && (bus.io_addr == TMR_COUNT);

  // en 0->1 restarts the prescaler phase.
  assign w_start  = w_wr_ctrl && bus.io_wdata[CTRL_EN] && !r_ctrl.en;
  assign w_pclear = w_start || w_wr_presc || w_wr_count;

  io_timer_prescale #(
    .PRESC_W (PRESC_W)
  ) u_prescale (
    .clk     (clk),
    .reset   (reset),
    .i_en    (r_ctrl.en),
    .i_clear (w_pclear),
    .i_presc (r_presc),
    .o_tick  (w_tick)
  );

  // A COUNT write in the same cycle as a tick swallows that tick entirely.
  assign w_tick_eff   = w_tick && !w_wr_count;
  assign w_expire     = w_tick_eff && (r_count == '0);
  assign w_clr_status = w_wr_status && bus.io_wdata[0];

  assign interrupt = r_expired && r_ctrl.ie;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_expired <= 1'b0;
      r_presc   <= '0;
      r_reload  <= '0;
      r_count   <= '0;
    end else begin
      if (w_tick_eff) begin
        if (r_count != '0) begin
          r_count <= r_count - 1'b1;
        end else if (r_ctrl.periodic) begin
          r_count <= r_reload;
        end
      end
      if (w_wr_count) begin
        r_count <= bus.io_wdata[CNT_W-1:0];
      end

      // Later assignment wins: an explicit CTRL write overrides the
      // one-shot auto-disable on the same edge.
      if (w_expire && !r_ctrl.periodic) begin
        r_ctrl.en <= 1'b0;
      end
      if (w_wr_ctrl) begin
        r_ctrl <= ctrl_from_word(bus.io_wdata[2:0]);
      end

      // Set beats a same-cycle write-1-to-clear.
      if (w_expire) begin
        r_expired <= 1'b1;
      end else if (w_clr_status) begin
        r_expired <= 1'b0;
      end

      if (w_wr_presc) begin
        r_presc <= bus.io_wdata[PRESC_W-1:0];
      end
      if (w_wr_reload) begin
        r_reload <= bus.io_wdata[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    bus.io_rdata = '0;
    case (bus.io_addr)
      TMR_CTRL:     bus.io_rdata = RV'(ctrl_to_word(r_ctrl));
      TMR_STATUS:   bus.io_rdata = RV'(r_expired);
      TMR_PRESCALE: bus.io_rdata = RV'(r_presc);
      TMR_RELOAD:   bus.io_rdata = RV'(r_reload);
      TMR_COUNT:    bus.io_rdata = RV'(r_count);
      default:      bus.io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_io_timer.sv
// -----------------------------------------------------------------------------
// tb_io_timer
//   Scoreboard bench for io_timer. The stimulus process drives one bus
//   operation per clock, pushes the reference model's expected read data and
//   interrupt level for that cycle, then advances the model at the clock edge.
//   The monitor pops one entry per negedge and compares it with the DUT.
//   The model tracks ticks as an absolute schedule (edge number of the next
//   tick) rather than a prescaler count.
// -----------------------------------------------------------------------------
module tb_io_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic interrupt;

  io_timer_if #(.RV(16)) bus ();

  io_timer #(
    .RV      (16),
    .PRESC_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit          m_en, m_per, m_ie, m_exp;
  int unsigned m_presc, m_reload, m_count;
  int unsigned m_edge;     // index of the upcoming clock edge
  int unsigned m_tick_at;  // edge at which the next tick takes effect

  typedef struct {
    bit          rd;
    logic [3:0]  addr;
    logic [15:0] rdata;
    bit          irq;
  } exp_t;

  exp_t sbq[$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic logic [15:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return {13'd0, m_ie, m_per, m_en};
      4'd1:    return {15'd0, m_exp};
      4'd2:    return 16'(m_presc);
      4'd3:    return 16'(m_reload);
      4'd4:    return 16'(m_count);
      default: return 16'd0;
    endcase
  endfunction

  function automatic void model_reset();
    m_en = 0; m_per = 0; m_ie = 0; m_exp = 0;
    m_presc = 0; m_reload = 0; m_count = 0; m_tick_at = 0;
  endfunction

  function automatic void model_step(input bit rst, input bit wr,
                                     input logic [3:0] a, input logic [15:0] d);
    bit tick;
    bit was_en;
    if (rst) begin
      model_reset();
    end else begin
      was_en = m_en;
      tick   = m_en && (m_edge == m_tick_at);
      if (wr && a == 4'd1 && d[0]) m_exp = 0;
      if (tick && !(wr && a == 4'd4)) begin
        m_tick_at = m_edge + m_presc + 1;
        if (m_count > 0) begin
          m_count = m_count - 1;
        end else begin
          m_exp = 1;
          if (m_per) m_count = m_reload;
          else       m_en = 0;
        end
      end
      if (wr) begin
        case (a)
          4'd0: begin
            if (d[0] && !was_en) m_tick_at = m_edge + m_presc + 1;
            m_en = d[0]; m_per = d[1]; m_ie = d[2];
          end
          4'd2: begin
            m_presc   = int'(d[7:0]);
            m_tick_at = m_edge + m_presc + 1;
          end
          4'd3: m_reload = int'(d);
          4'd4: begin
            m_count   = int'(d);
            m_tick_at = m_edge + m_presc + 1;
          end
          default: ;
        endcase
      end
    end
    m_edge = m_edge + 1;
  endfunction

  function automatic bool_expiring();
    return m_en && (m_edge == m_tick_at) && (m_count == 0);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic drive_push(input bit rst, input bit wr, input logic [3:0] a,
                            input logic [15:0] d, input bit rd);
    exp_t x;
    reset        = rst;
    bus.io_write = wr;
    bus.io_addr  = a;
    bus.io_wdata = d;
    bus.io_read  = rd;
    x.rd    = rd;
    x.addr  = a;
    x.rdata = model_read(a);
    x.irq   = m_exp && m_ie;
    sbq.push_back(x);
  endtask

  task automatic cycle(input bit rst, input bit wr, input logic [3:0] a,
                       input logic [15:0] d, input bit rd);
    drive_push(rst, wr, a, d, rd);
    @(posedge clk);
    model_step(rst, wr, a, d);
    #1;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
    cycle(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic idle(input int unsigned n, input logic [3:0] a);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, a, 16'd0, 1'b1);
  endtask

  // Read cycle with an additional fixed expectation on data and interrupt.
  task automatic peek(input string nm, input logic [3:0] a,
                      input logic [15:0] want, input bit want_irq);
    drive_push(1'b0, 1'b0, a, 16'd0, 1'b1);
    @(negedge clk);
    #1;
    chk(nm, bus.io_rdata, want);
    chk({nm, "_irq"}, 16'(interrupt), 16'(want_irq));
    @(posedge clk);
    model_step(1'b0, 1'b0, a, 16'd0);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      total++;
      if (interrupt !== x.irq) begin
        bad++;
        $display("FAIL sb_irq t=%0t: got %b want %b", $time, interrupt, x.irq);
      end
      if (x.rd) begin
        total++;
        if (bus.io_rdata !== x.rdata) begin
          bad++;
          $display("FAIL sb_rdata t=%0t addr=%0d: got %h want %h",
                   $time, x.addr, bus.io_rdata, x.rdata);
        end
      end
    end
  end

  initial begin
    bit found;
    int unsigned r;
    logic [3:0]  a;
    logic [15:0] d;

    bus.io_write = 1'b0;
    bus.io_read  = 1'b0;
    bus.io_addr  = 4'd0;
    bus.io_wdata = 16'd0;
    m_edge = 0;
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    m_edge = m_edge + 1;
    #1;

    // T1: reset values and idle behaviour.
    cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b1);
    cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b1);
    for (int unsigned i = 0; i < 6; i++) peek("t1_reg", 4'(i), 16'd0, 1'b0);
    for (int unsigned i = 0; i < 100; i++) idle(1, 4'($urandom_range(0, 5)));
    peek("t1_count_after", 4'd4, 16'd0, 1'b0);

    // T2: periodic, 20-clk period.
    wr_reg(4'd2, 16'd3);
    wr_reg(4'd3, 16'd4);
    wr_reg(4'd4, 16'd4);
    wr_reg(4'd0, 16'd7);
    for (int unsigned i = 0; i < 45; i++) idle(1, (i % 2 == 0) ? 4'd1 : 4'd4);
    wr_reg(4'd1, 16'd1);
    idle(30, 4'd1);

    // T6: reset mid-run at count 2.
    found = 0;
    for (int unsigned i = 0; i < 100 && !found; i++) begin
      if (m_count == 2) found = 1;
      else idle(1, 4'd4);
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL t6_wait: count 2 not reached, got %0d want 2", m_count);
    end
    cycle(1'b1, 1'b0, 4'd4, 16'd0, 1'b1);
    peek("t6_ctrl", 4'd0, 16'd0, 1'b0);
    peek("t6_status", 4'd1, 16'd0, 1'b0);
    peek("t6_presc", 4'd2, 16'd0, 1'b0);
    peek("t6_reload", 4'd3, 16'd0, 1'b0);
    peek("t6_count", 4'd4, 16'd0, 1'b0);

    // T3: one-shot, expires 3 clks after enable.
    wr_reg(4'd2, 16'd0);
    wr_reg(4'd4, 16'd2);
    wr_reg(4'd0, 16'd5);
    idle(3, 4'd1);
    peek("t3_status", 4'd1, 16'd1, 1'b1);
    peek("t3_ctrl", 4'd0, 16'd4, 1'b1);
    idle(5, 4'd4);
    peek("t3_count", 4'd4, 16'd0, 1'b1);

    // T4: W1C on the expiring cycle.
    cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b0);
    wr_reg(4'd2, 16'd1);
    wr_reg(4'd3, 16'd3);
    wr_reg(4'd4, 16'd3);
    wr_reg(4'd0, 16'd7);
    found = 0;
    for (int unsigned i = 0; i < 100 && !found; i++) begin
      if (bool_expiring()) begin
        wr_reg(4'd1, 16'd1);
        found = 1;
      end else begin
        idle(1, 4'd4);
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL t4_wait: no expiry within bound, got 0 want 1");
    end
    peek("t4_status", 4'd1, 16'd1, 1'b1);

    // T5: COUNT write on the expiring tick.
    cycle(1'b1, 1'b0, 4'd0, 16'd0, 1'b0);
    wr_reg(4'd2, 16'd2);
    wr_reg(4'd4, 16'd1);
    wr_reg(4'd0, 16'd1);
    found = 0;
    for (int unsigned i = 0; i < 100 && !found; i++) begin
      if (bool_expiring()) begin
        wr_reg(4'd4, 16'd9);
        found = 1;
      end else begin
        idle(1, 4'd4);
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL t5_wait: no expiry within bound, got 0 want 1");
    end
    peek("t5_count", 4'd4, 16'd9, 1'b0);
    peek("t5_status", 4'd1, 16'd0, 1'b0);

    // Randomized traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      a = 4'($urandom_range(0, 7));
      if (r < 1) begin
        cycle(1'b1, 1'b0, a, 16'd0, 1'b1);
      end else if (r < 50) begin
        case (a)
          4'd0:    d = 16'($urandom) | 16'(($urandom_range(0, 3) != 0) ? 1 : 0);
          4'd2:    d = (16'($urandom) & 16'hFF00) | 16'($urandom_range(0, 3));
          4'd3:    d = 16'($urandom_range(0, 8));
          4'd4:    d = 16'($urandom_range(0, 12));
          default: d = 16'($urandom);
        endcase
        cycle(1'b0, 1'b1, a, d, 1'b0);
      end else begin
        cycle(1'b0, 1'b0, a, 16'd0, 1'b1);
      end
    end
    idle(2, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
